// File: rtl/debug_ocimem_arbiter_if.sv
// Avalon debug-memory slave bundle between the CPU-side master and the OCI RAM arbiter.
// The arbiter drives waitrequest/readdata; the master holds a request until waitrequest drops.
interface debug_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_waitrequest, avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_waitrequest, avs_readdata
  );
endinterface

// File: rtl/debug_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the JTAG monitor path and the Avalon slave; writes take 1 cycle, reads 2.
// Avalon is stalled via waitrequest while JTAG owns the RAM; a JTAG pulse arriving while one is pending is dropped and flagged.
module debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [37:0]           jdo,
  output logic [DATA_W-1:0]     MonDReg,
  output logic [ADDR_W-1:0]     MonAReg,
  output logic                  monitor_ready,
  output logic                  jtag_overrun,
  debug_ocimem_arbiter_if.slave avs,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_JWR,
    S_JRD,
    S_JRD_CAP,
    S_AWR,
    S_ARD,
    S_ARD_CAP
  } state_t;

  state_t              state_q, state_d, op;
  logic                jtag_pend_q, jtag_pend_d;
  logic                jtag_wr_q, jtag_wr_d;
  logic [DATA_W-1:0]   jtag_wdata_q, jtag_wdata_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [DATA_W-1:0]   mon_d_q, mon_d_d;
  logic                overrun_q, overrun_d;
  logic                last_jtag_q, last_jtag_d;
  logic                arb_en_q, arb_en_d;
  logic                avs_req;
  logic                avs_done;
  logic [ADDR_W-1:0]   mon_a_inc;

  wire unused_jdo_bits = &{1'b0, jdo[37:35], jdo[2:0]};

  assign avs_req   = avs.avs_read | avs.avs_write;
  assign mon_a_inc = mon_a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  // Holds off arbitration for the first cycle after reset release so a request
  // held across reset cannot reach the RAM while reset is still asserted.
  assign arb_en_d  = 1'b1;

  always_comb begin
    op           = state_q;
    state_d      = S_IDLE;
    jtag_pend_d  = jtag_pend_q;
    jtag_wr_d    = jtag_wr_q;
    jtag_wdata_d = jtag_wdata_q;
    mon_a_d      = mon_a_q;
    mon_d_d      = mon_d_q;
    overrun_d    = overrun_q;
    last_jtag_d  = last_jtag_q;
    ram_addr     = mon_a_q;
    ram_wren     = 1'b0;
    ram_wdata    = jtag_wdata_q;
    avs_done     = 1'b0;

    // The grant cycle already performs the first phase of the winning operation.
    if (state_q == S_IDLE && arb_en_q) begin
      if (jtag_pend_q && (!avs_req || !last_jtag_q)) begin
        op = jtag_wr_q ? S_JWR : S_JRD;
      end else if (avs_req) begin
        op = avs.avs_write ? S_AWR : S_ARD;
      end
    end

    case (op)
      S_JWR: begin
        ram_wren    = 1'b1;
        mon_d_d     = jtag_wdata_q;
        mon_a_d     = mon_a_inc;
        jtag_pend_d = 1'b0;
        last_jtag_d = 1'b1;
      end
      S_JRD: begin
        state_d     = S_JRD_CAP;
        last_jtag_d = 1'b1;
      end
      S_JRD_CAP: begin
        mon_d_d     = ram_rdata;
        mon_a_d     = mon_a_inc;
        jtag_pend_d = 1'b0;
      end
      S_AWR: begin
        ram_addr    = avs.avs_address;
        ram_wren    = 1'b1;
        ram_wdata   = avs.avs_writedata;
        avs_done    = 1'b1;
        last_jtag_d = 1'b0;
      end
      S_ARD: begin
        ram_addr    = avs.avs_address;
        state_d     = S_ARD_CAP;
        last_jtag_d = 1'b0;
      end
      S_ARD_CAP: begin
        ram_addr = avs.avs_address;
        avs_done = 1'b1;
      end
      default: ;
    endcase

    // Address load overrides the post-access increment issued in the same cycle.
    if (take_action_ocimem_a) begin
      mon_a_d   = jdo[17 +: ADDR_W];
      overrun_d = 1'b0;
    end

    if (take_no_action_ocimem_a || take_action_ocimem_b) begin
      if (jtag_pend_q) begin
        overrun_d = 1'b1;
      end else begin
        jtag_pend_d  = 1'b1;
        jtag_wr_d    = take_action_ocimem_b;
        jtag_wdata_d = jdo[3 +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_wdata_q <= '0;
      mon_a_q      <= '0;
      mon_d_q      <= '0;
      overrun_q    <= 1'b0;
      last_jtag_q  <= 1'b0;
      arb_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      jtag_pend_q  <= jtag_pend_d;
      jtag_wr_q    <= jtag_wr_d;
      jtag_wdata_q <= jtag_wdata_d;
      mon_a_q      <= mon_a_d;
      mon_d_q      <= mon_d_d;
      overrun_q    <= overrun_d;
      last_jtag_q  <= last_jtag_d;
      arb_en_q     <= arb_en_d;
    end
  end

  assign MonAReg             = mon_a_q;
  assign MonDReg             = mon_d_q;
  assign monitor_ready       = ~jtag_pend_q;
  assign jtag_overrun        = overrun_q;
  assign avs.avs_waitrequest = avs_req & ~avs_done;
  assign avs.avs_readdata    = ram_rdata;

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Bench for debug_ocimem_arbiter: directed scenarios plus randomized JTAG/Avalon traffic,
// checked every cycle against a transaction-level model with its own copy of the RAM.
module tb_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [37:0] jdo = '0;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready, jtag_overrun;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  debug_ocimem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) avs_if ();

  debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .jdo                     (jdo),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun),
    .avs                     (avs_if),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 255) return 32'h12345678;
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Physical RAM: 1-cycle registered read.
  logic [31:0] ram [256];
  logic        ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else begin
      ram_rdata <= ram[ram_addr];
      if (ram_wren) ram[ram_addr] <= ram_wdata;
    end
  end

  // Transaction-level reference model, evaluated once per cycle at the falling edge.
  logic [31:0] mmem [256];
  bit          m_init = 1'b0;
  logic [7:0]  m_a;
  logic [31:0] m_d, m_wdata, cap_data;
  bit          m_pend, m_wr, m_over, last_j, armed, busy, cap_j;
  bit          areq, e_wait, e_wren, addr_chk, rd_chk, old_pend;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata;

  always @(negedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
      m_init = 1'b1;
    end
    if (!reset_n) begin
      m_a = 8'h00; m_d = 32'h0; m_pend = 0; m_over = 0; last_j = 0; armed = 0; busy = 0;
      chk("rst_monitor_ready", 32'(monitor_ready), 32'd1);
      chk("rst_MonAReg", 32'(MonAReg), 32'd0);
      chk("rst_MonDReg", MonDReg, 32'd0);
      chk("rst_overrun", 32'(jtag_overrun), 32'd0);
      chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    end else begin
      areq = avs_if.avs_read | avs_if.avs_write;
      chk("monitor_ready", 32'(monitor_ready), 32'(!m_pend));
      chk("MonAReg", 32'(MonAReg), 32'(m_a));
      chk("MonDReg", MonDReg, m_d);
      chk("jtag_overrun", 32'(jtag_overrun), 32'(m_over));
      e_wait = areq; e_wren = 0; addr_chk = 0; rd_chk = 0; e_addr = m_a; e_wdata = 32'h0;
      old_pend = m_pend;
      if (busy) begin
        busy = 0;
        if (cap_j) begin
          m_d = cap_data; m_a = m_a + 8'd1; m_pend = 0;
        end else begin
          e_wait = 0; rd_chk = 1;
        end
      end else if (armed && (m_pend || areq)) begin
        if (m_pend && !(areq && last_j)) begin
          last_j = 1; e_addr = m_a; addr_chk = 1;
          if (m_wr) begin
            e_wren = 1; e_wdata = m_wdata; mmem[m_a] = m_wdata;
            m_d = m_wdata; m_a = m_a + 8'd1; m_pend = 0;
          end else begin
            cap_data = mmem[m_a]; cap_j = 1; busy = 1;
          end
        end else begin
          last_j = 0; e_addr = avs_if.avs_address; addr_chk = 1;
          if (avs_if.avs_write) begin
            e_wren = 1; e_wdata = avs_if.avs_writedata; e_wait = 0;
            mmem[avs_if.avs_address] = avs_if.avs_writedata;
          end else begin
            cap_data = mmem[avs_if.avs_address]; cap_j = 0; busy = 1;
          end
        end
      end
      chk("avs_waitrequest", 32'(avs_if.avs_waitrequest), 32'(e_wait));
      chk("ram_wren", 32'(ram_wren), 32'(e_wren));
      if (addr_chk) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_wren) chk("ram_wdata", ram_wdata, e_wdata);
      if (rd_chk) chk("avs_readdata", avs_if.avs_readdata, cap_data);
      if (ta_a) begin m_a = jdo[24:17]; m_over = 0; end
      if (tna_a || ta_b) begin
        if (old_pend) m_over = 1;
        else begin m_pend = 1; m_wr = ta_b; m_wdata = jdo[34:3]; end
      end
      armed = 1;
    end
  end

  function automatic logic [37:0] jdo_a(input logic [7:0] a);
    return {13'b0, a, 17'b0};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    return {3'b0, d, 3'b0};
  endfunction

  // All driver tasks start and end at a cycle start (1 time unit after the rising edge).
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic jtag_pulse(input int kind, input logic [37:0] d);
    jdo = d;
    case (kind)
      0:       ta_a  = 1'b1;
      1:       tna_a = 1'b1;
      default: ta_b  = 1'b1;
    endcase
    @(posedge clk); #1;
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!monitor_ready && n < bound) begin @(posedge clk); #1; n++; end
    chk("ready_reached", 32'(monitor_ready), 32'd1);
  endtask

  task automatic avs_wait(output logic [31:0] rdata, output int waits);
    bit done = 1'b0;
    waits = 0; rdata = 32'h0;
    while (!done) begin
      @(negedge clk);
      if (!avs_if.avs_waitrequest) begin
        rdata = avs_if.avs_readdata; done = 1'b1;
      end else begin
        waits++;
        if (waits > 40) begin chk("avs_timeout", 32'(waits), 32'd0); done = 1'b1; end
      end
    end
    @(posedge clk); #1;
    avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
  endtask

  task automatic avs_op(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output int waits);
    avs_if.avs_address = a; avs_if.avs_writedata = wd;
    avs_if.avs_write = wr; avs_if.avs_read = !wr;
    avs_wait(rdata, waits);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  logic [31:0] rd;
  int          w, max_w;

  initial begin
    avs_if.avs_address = 8'h00; avs_if.avs_read = 1'b0;
    avs_if.avs_write = 1'b0; avs_if.avs_writedata = 32'h0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(monitor_ready), 32'd1);
    chk("reset_MonAReg", 32'(MonAReg), 32'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // JTAG write at 0x10
    jtag_pulse(0, jdo_a(8'h10));
    jtag_pulse(2, jdo_b(32'hDEADBEEF));
    chk("jwr_busy_t1", 32'(monitor_ready), 32'd0);
    idle(1);
    chk("jwr_ready_t2", 32'(monitor_ready), 32'd1);
    chk("jwr_ram", ram[8'h10], 32'hDEADBEEF);
    chk("jwr_MonAReg", 32'(MonAReg), 32'h11);
    chk("jwr_MonDReg", MonDReg, 32'hDEADBEEF);

    // JTAG read at 0xFF with address wrap
    jtag_pulse(0, jdo_a(8'hFF));
    jtag_pulse(1, 38'h0);
    chk("jrd_busy_t1", 32'(monitor_ready), 32'd0);
    idle(1);
    chk("jrd_busy_t2", 32'(monitor_ready), 32'd0);
    idle(1);
    chk("jrd_ready_t3", 32'(monitor_ready), 32'd1);
    chk("jrd_MonDReg", MonDReg, 32'h12345678);
    chk("jrd_MonAReg_wrap", 32'(MonAReg), 32'h00);

    // Avalon write then read
    avs_op(1'b1, 8'h20, 32'hCAFEF00D, rd, w);
    chk("awr_waits", 32'(w), 32'd0);
    avs_op(1'b0, 8'h20, 32'h0, rd, w);
    chk("ard_waits", 32'(w), 32'd1);
    chk("ard_data", rd, 32'hCAFEF00D);

    // Continuous Avalon reads against JTAG reads every 4 cycles
    jtag_pulse(0, jdo_a(8'h40));
    max_w = 0;
    fork
      begin
        repeat (20) begin
          avs_op(1'b0, 8'($urandom_range(0, 255)), 32'h0, rd, w);
          if (w > max_w) max_w = w;
        end
      end
      begin
        repeat (8) begin jtag_pulse(1, 38'h0); idle(3); end
      end
    join
    wait_ready(20);
    chk("mix_MonAReg", 32'(MonAReg), 32'h48);
    chk("mix_overrun", 32'(jtag_overrun), 32'd0);
    chk("mix_avs_max_stall_le3", 32'(max_w <= 3), 32'd1);

    // Overrun: second write pulse dropped
    jtag_pulse(0, jdo_a(8'h50));
    jtag_pulse(2, jdo_b(32'h11111111));
    jtag_pulse(2, jdo_b(32'h22222222));
    wait_ready(10);
    chk("ovr_flag", 32'(jtag_overrun), 32'd1);
    chk("ovr_first_lands", ram[8'h50], 32'h11111111);
    chk("ovr_second_dropped", ram[8'h51], 32'hF4F45151);
    chk("ovr_MonAReg", 32'(MonAReg), 32'h51);
    jtag_pulse(0, jdo_a(8'h60));
    chk("ovr_cleared", 32'(jtag_overrun), 32'd0);
    chk("ovr_MonAReg_load", 32'(MonAReg), 32'h60);

    // Reset during a JTAG read
    jtag_pulse(0, jdo_a(8'h70));
    jtag_pulse(1, 38'h0);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("jrd_rst_ready", 32'(monitor_ready), 32'd1);
    chk("jrd_rst_MonDReg", MonDReg, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Reset during an Avalon write; the held request restarts afterwards
    avs_if.avs_address = 8'h30; avs_if.avs_writedata = 32'h0BADF00D;
    avs_if.avs_write = 1'b1; avs_if.avs_read = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("awr_rst_wren", 32'(ram_wren), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("awr_rst_no_write", ram[8'h30], 32'h95953030);
    avs_wait(rd, w);
    chk("awr_restart_write", ram[8'h30], 32'h0BADF00D);

    // Randomized concurrent traffic
    max_w = 0;
    fork
      begin
        repeat (150) begin
          idle($urandom_range(0, 3));
          avs_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom, rd, w);
          if (w > max_w) max_w = w;
        end
      end
      begin
        repeat (180) begin
          idle($urandom_range(0, 4));
          jtag_pulse(int'($urandom_range(0, 2)), {6'($urandom), 32'($urandom)});
        end
      end
    join
    wait_ready(20);
    idle(3);
    chk("rand_avs_max_stall_le3", 32'(max_w <= 3), 32'd1);
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== mmem[i]) bad++;
      chk("ram_image_mismatches", 32'(bad), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/debug_ocimem_arbiter.md
# debug_ocimem_arbiter

Sequencer and arbiter for the debug-module on-chip memory (OCI RAM, 256×32, single port, 1-cycle read latency). It shares the RAM between two requesters:
- the JTAG debug path, driven by the `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses and `jdo` from the debug-slave sysclk block;
- the CPU-side Avalon debug memory slave.

It serialises accesses, holds the JTAG address/data monitor registers, and reports JTAG readiness back to the debug-slave TCK block.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width
- DATA_W, 32, RAM/data width (fixed 32 for JTAG path)

Ports:
- clk  in  1  system clock; one clock domain
- reset_n  in  1  reset, asynchronous, active-low
- take_action_ocimem_a  in  1  pulse: load MonAReg from jdo[17+ADDR_W-1:17], clear jtag_overrun
- take_no_action_ocimem_a  in  1  pulse: JTAG read at MonAReg
- take_action_ocimem_b  in  1  pulse: JTAG write jdo[34:3] at MonAReg
- jdo  in  38  JTAG data-out shift register contents
- MonDReg  out  32  JTAG read data / last written data
- MonAReg  out  ADDR_W  JTAG address register
- monitor_ready  out  1  no JTAG operation pending
- jtag_overrun  out  1  sticky: a JTAG pulse arrived while one was pending
- avs_address  in  ADDR_W  Avalon word address
- avs_read / avs_write  in  1  Avalon requests (mutually exclusive)
- avs_writedata  in  32  Avalon write data
- avs_waitrequest  out  1  Avalon stall
- avs_readdata  out  32  Avalon read data
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid 1 cycle after address

## Operation
- JTAG pulses are latched into `jtag_pend` plus an op type (RD/WR) and write data; `monitor_ready` = ~jtag_pend.
- A JTAG pulse while `jtag_pend`=1 is dropped and sets `jtag_overrun`.
- `take_action_ocimem_a` is accepted at any time. It loads MonAReg immediately, even while an operation is pending; the pending operation uses the new address.
- FSM states: IDLE, JWR, JRD, JRD_CAP, AWR, ARD, ARD_CAP. Transitions:
  - IDLE → JWR/JRD when `jtag_pend` wins arbitration.
  - IDLE → AWR/ARD when an Avalon request wins.
  - JWR, AWR, JRD_CAP, ARD_CAP → IDLE.
  - JRD → JRD_CAP; ARD → ARD_CAP.
- Arbitration happens in IDLE only. If both requesters are pending, grant goes to the requester not granted last (`last_grant`). A single requester is always granted.
- JWR: ram_addr=MonAReg, ram_wren=1, ram_wdata=latched data, MonDReg←data, MonAReg+1, clear jtag_pend.
- JRD: ram_addr=MonAReg. JRD_CAP: MonDReg←ram_rdata, MonAReg+1, clear jtag_pend.
- AWR: ram_addr=avs_address, ram_wren=1, ram_wdata=avs_writedata, avs_waitrequest=0.
- ARD: ram_addr=avs_address. ARD_CAP: avs_readdata=ram_rdata, avs_waitrequest=0.
- avs_waitrequest = (avs_read|avs_write) & ~(state==AWR | state==ARD_CAP). It is 0 when there is no request.
- MonAReg increments modulo 2^ADDR_W: 255 → 0.
- ram_wren is asserted only in JWR/AWR. ram_addr is MonAReg in IDLE.

## Timing
- Reset values: state IDLE, MonDReg 0, MonAReg 0, monitor_ready 1, jtag_overrun 0, jtag_pend 0, last_grant=AVALON (so JTAG wins the first tie), ram_wren 0.
- JTAG pulse at cycle t: jtag_pend=1 at t+1; earliest grant at t+1.
  - Write: commits at t+1; monitor_ready=1 at t+2.
  - Read: MonDReg valid and monitor_ready=1 at t+3.
- Avalon: a request held in IDLE with a win at cycle t completes as follows.
  - Write: waitrequest=0 at t.
  - Read: waitrequest=0 at t+1, with readdata valid that cycle.
  - Back-to-back contention: the maximum Avalon stall is one JTAG operation (2 cycles) plus its own.
- A JTAG pulse arriving in the same cycle an Avalon request starts does not preempt it, because the pulse is not yet latched.
- Asynchronous reset mid-operation: abort immediately, no RAM write after reset assertion, pending JTAG op discarded. A held Avalon request restarts after reset release.

## Test plan
- Reset, then JTAG `take_action_ocimem_a` with address 0x10, `take_action_ocimem_b` with data 0xDEADBEEF → RAM[0x10]=0xDEADBEEF, MonAReg=0x11, monitor_ready high 2 cycles after the write pulse.
- JTAG read at 0xFF preloaded with 0x12345678 → MonDReg=0x12345678 at t+3, MonAReg wraps to 0x00.
- Avalon write 0xCAFEF00D at 0x20, then read → write waitrequest low in the grant cycle; read returns 0xCAFEF00D with waitrequest low exactly 1 cycle after grant.
- Continuous Avalon reads plus JTAG reads every 4 cycles → grants alternate, no lost op, JTAG never waits more than one Avalon op.
- Two JTAG write pulses 1 cycle apart → second dropped, jtag_overrun=1, only the first write lands; `take_action_ocimem_a` clears overrun.
- reset_n low during JRD/AWR → no RAM write after assertion, all outputs at reset values, monitor_ready=1.
